// File: rtl/demorgan_sweep.sv
// Sweeps every N_INPUTS-bit vector and checks direct AND/NAND/OR/NOR against their De Morgan duals.
// One row per vector every SETTLE_CYCLES+1 cycles; start is ignored unless idle.
module demorgan_sweep #(
  parameter int N_INPUTS      = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [3:0]          fault_mask,
  input  logic [N_INPUTS-1:0] fault_vec,
  output logic                busy,
  output logic                row_valid,
  output logic [N_INPUTS-1:0] vec,
  output logic                and_o,
  output logic                nand_o,
  output logic                or_o,
  output logic                nor_o,
  output logic                row_mismatch,
  output logic [N_INPUTS:0]   mismatch_count,
  output logic [N_INPUTS-1:0] first_fail_vec,
  output logic                done,
  output logic                pass
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t              state_q, state_d;
  logic [N_INPUTS-1:0] vec_q, vec_d;
  logic [CW-1:0]       settle_q, settle_d;
  logic [N_INPUTS:0]   count_q, count_d;
  logic [N_INPUTS-1:0] first_fail_q, first_fail_d;
  logic                pass_q, pass_d;

  logic [3:0] direct_forms, dual_forms, fault_xor;
  logic       mismatch;

  assign and_o  = &vec_q;
  assign nand_o = ~&vec_q;
  assign or_o   = |vec_q;
  assign nor_o  = ~|vec_q;

  // Bit order {nor, or, nand, and} matches fault_mask.
  assign direct_forms = {nor_o, or_o, nand_o, and_o};
  assign fault_xor    = (vec_q == fault_vec) ? fault_mask : 4'b0000;
  assign dual_forms   = {&(~vec_q), ~&(~vec_q), |(~vec_q), ~|(~vec_q)} ^ fault_xor;
  assign mismatch     = (dual_forms != direct_forms);

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    settle_d     = settle_q;
    count_d      = count_q;
    first_fail_d = first_fail_q;
    pass_d       = pass_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = SETTLE;
          vec_d        = '0;
          settle_d     = '0;
          count_d      = '0;
          first_fail_d = '0;
          pass_d       = 1'b0;
        end
      end
      SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = CHECK;
        else                         settle_d = settle_q + CW'(1);
      end
      CHECK: begin
        if (mismatch) begin
          count_d = count_q + (N_INPUTS+1)'(1);
          if (count_q == '0) first_fail_d = vec_q;
        end
        // All-ones is the last row; vec never wraps.
        if (&vec_q) begin
          state_d = DONE;
        end else begin
          vec_d    = vec_q + N_INPUTS'(1);
          settle_d = '0;
          state_d  = SETTLE;
        end
      end
      DONE: begin
        pass_d  = (count_q == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      vec_q        <= '0;
      settle_q     <= '0;
      count_q      <= '0;
      first_fail_q <= '0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      settle_q     <= settle_d;
      count_q      <= count_d;
      first_fail_q <= first_fail_d;
      pass_q       <= pass_d;
    end
  end

  assign busy           = (state_q == SETTLE) || (state_q == CHECK);
  assign row_valid      = (state_q == CHECK);
  assign done           = (state_q == DONE);
  assign row_mismatch   = row_valid && mismatch;
  assign vec            = vec_q;
  assign mismatch_count = count_q;
  assign first_fail_vec = first_fail_q;
  assign pass           = pass_q;

endmodule
